segre_store_buffer_fifo: RTL and testbench

//  Parametrised N-entry FIFO store buffer between the TL stage and the data cache.

---
 rtl/segre_store_buffer_fifo.sv | 160 ++++++++++++++++
 tb/tb_segre_store_buffer_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/segre_store_buffer_fifo.sv
// In-order store buffer between TL stage and dcache: byte-enable tracking, youngest-match load forwarding,
// partial-overlap "trouble" flag. Optional store merging into the youngest entry via SEGRE_SB_COALESCE_EN.
module segre_store_buffer_fifo #(
  parameter int NUM_ELEMS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    req_store_i,
  input  logic                    req_load_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [31:0]             data_i,
  input  logic [1:0]              data_type_i,
  output logic                    hit_o,
  output logic                    miss_o,
  output logic                    trouble_o,
  output logic [31:0]             data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    drain_valid_o,
  input  logic                    drain_ready_i,
  output logic [ADDR_W-1:0]       drain_addr_o,
  output logic [DATA_W-1:0]       drain_data_o,
  output logic [DATA_W/8-1:0]     drain_be_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int PTR_W  = $clog2(NUM_ELEMS);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = ADDR_W - OFF_W;

  localparam logic [1:0] DT_BYTE = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;

  logic [LANE_W-1:0] lane_q [NUM_ELEMS];
  logic [BE_W-1:0]   be_q   [NUM_ELEMS];
  logic [DATA_W-1:0] data_q [NUM_ELEMS];
  logic [NUM_ELEMS-1:0] valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [OFF_W-1:0]  size_m1, acc_off;
  logic [3:0]        be4;
  logic [31:0]       size_mask;
  logic [BE_W-1:0]   acc_be;
  logic [DATA_W-1:0] st_data, st_bitmask;
  logic [LANE_W-1:0] acc_lane;

  // The access decode is shared: a store and a load in the same cycle use the same address.
  always_comb begin
    case (data_type_i)
      DT_BYTE: begin size_m1 = OFF_W'(0); be4 = 4'b0001; size_mask = 32'h0000_00FF; end
      DT_HALF: begin size_m1 = OFF_W'(1); be4 = 4'b0011; size_mask = 32'h0000_FFFF; end
      default: begin size_m1 = OFF_W'(3); be4 = 4'b1111; size_mask = 32'hFFFF_FFFF; end
    endcase
    acc_off  = addr_i[OFF_W-1:0] & ~size_m1;
    acc_be   = BE_W'(be4) << acc_off;
    st_data  = DATA_W'(data_i & size_mask) << {acc_off, 3'b000};
    acc_lane = addr_i[ADDR_W-1:OFF_W];
    for (int b = 0; b < BE_W; b++) begin
      st_bitmask[8*b +: 8] = {8{acc_be[b]}};
    end
  end

  assign full_o        = (count_q == CNT_W'(NUM_ELEMS));
  assign empty_o       = (count_q == '0);
  assign drain_valid_o = !empty_o;
  assign drain_addr_o  = {lane_q[head_q], {OFF_W{1'b0}}};
  assign drain_data_o  = data_q[head_q];
  assign drain_be_o    = be_q[head_q];

  logic             found;
  logic [PTR_W-1:0] fidx, idx;

  // Walk oldest to youngest so the last overlapping match is the youngest.
  always_comb begin
    found     = 1'b0;
    fidx      = '0;
    idx       = '0;
    hit_o     = 1'b0;
    miss_o    = 1'b0;
    trouble_o = 1'b0;
    data_o    = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      idx = head_q + PTR_W'(k);
      if (valid_q[idx] && lane_q[idx] == acc_lane && |(be_q[idx] & acc_be)) begin
        found = 1'b1;
        fidx  = idx;
      end
    end
    if (req_load_i) begin
      if (!found) begin
        miss_o = 1'b1;
      end else if ((be_q[fidx] & acc_be) == acc_be) begin
        hit_o  = 1'b1;
        data_o = 32'(data_q[fidx] >> {acc_off, 3'b000}) & size_mask;
      end else begin
        trouble_o = 1'b1;
      end
    end
  end

  logic pop, push, coalesce;
  assign pop = drain_valid_o && drain_ready_i;

`ifdef SEGRE_SB_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail_q - PTR_W'(1);
  // Never merge into the head while it is leaving: the merged bytes would be lost.
  assign coalesce = req_store_i && !empty_o && valid_q[youngest] &&
                    lane_q[youngest] == acc_lane && !(pop && youngest == head_q);
`else
  assign coalesce = 1'b0;
`endif

  assign push = req_store_i && !full_o && !coalesce;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        lane_q[i] <= '0;
        be_q[i]   <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        lane_q[head_q]  <= '0;
        be_q[head_q]    <= '0;
        data_q[head_q]  <= '0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        lane_q[tail_q]  <= acc_lane;
        be_q[tail_q]    <= acc_be;
        data_q[tail_q]  <= st_data;
        tail_q          <= tail_q + PTR_W'(1);
      end
`ifdef SEGRE_SB_COALESCE_EN
      if (coalesce) begin
        data_q[youngest] <= (data_q[youngest] & ~st_bitmask) | (st_data & st_bitmask);
        be_q[youngest]   <= be_q[youngest] | acc_be;
      end
`endif
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_store_buffer_fifo.sv
// Randomized + directed bench for segre_store_buffer_fifo; byte-level queue reference model and scoreboard.
module tb_segre_store_buffer_fifo;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        req_store = 1'b0, req_load = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [1:0]  dtype = 2'd0;
  logic        hit, miss, trouble, full, empty, dvld;
  logic        drdy = 1'b0;
  logic [31:0] dout, daddr, ddata;
  logic [3:0]  dbe;

  always #5 clk = ~clk;

  segre_store_buffer_fifo #(.NUM_ELEMS(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rsn_i(rsn), .req_store_i(req_store), .req_load_i(req_load),
    .addr_i(addr), .data_i(data), .data_type_i(dtype),
    .hit_o(hit), .miss_o(miss), .trouble_o(trouble), .data_o(dout),
    .full_o(full), .empty_o(empty), .drain_valid_o(dvld), .drain_ready_i(drdy),
    .drain_addr_o(daddr), .drain_data_o(ddata), .drain_be_o(dbe)
  );

  typedef struct {
    logic [29:0] lane;
    logic [3:0]  be;
    logic [31:0] bytes;
  } ent_t;

  typedef struct {
    bit          ld;
    bit          hit, miss, tr;
    logic [31:0] data;
    bit          empty, full, dvld;
    logic [31:0] daddr, ddata;
    logic [3:0]  dbe;
  } rec_t;

  ent_t mq[$];
  rec_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Byte count, aligned offset, lane and byte-enable of an access.
  task automatic decode(input logic [31:0] a, input logic [1:0] dt,
                        output int sz, output int off, output logic [29:0] lane, output logic [3:0] be);
    sz   = (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]) / sz * sz;
    lane = a[31:2];
    be   = 4'b0000;
    for (int j = 0; j < sz; j++) be[off + j] = 1'b1;
  endtask

  // One clock cycle of stimulus; expectation is derived from the model state before the edge.
  task automatic step(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] dt, input bit rdy);
    int sz, off, found;
    logic [29:0] lane;
    logic [3:0]  be;
    rec_t r;
    bit pop, coal;
    @(posedge clk); #1;
    req_store = st; req_load = ld; addr = a; data = d; dtype = dt; drdy = rdy;
    decode(a, dt, sz, off, lane, be);
    r = '{default: 0};
    r.ld = ld;
    if (ld) begin
      found = -1;
      for (int i = mq.size() - 1; i >= 0 && found < 0; i--)
        if (mq[i].lane == lane && (mq[i].be & be) != 4'b0) found = i;
      if (found < 0) r.miss = 1;
      else if ((mq[found].be & be) == be) begin
        r.hit = 1;
        for (int j = 0; j < sz; j++) r.data[8*j +: 8] = mq[found].bytes[8*(off+j) +: 8];
      end else r.tr = 1;
    end
    r.empty = (mq.size() == 0);
    r.full  = (mq.size() == N);
    r.dvld  = (mq.size() > 0);
    if (r.dvld) begin
      r.daddr = {mq[0].lane, 2'b00};
      r.ddata = mq[0].bytes;
      r.dbe   = mq[0].be;
    end
    exp_q.push_back(r);
    pop  = rdy && mq.size() > 0;
    coal = 0;
`ifdef SEGRE_SB_COALESCE_EN
    coal = st && mq.size() > 0 && mq[mq.size()-1].lane == lane && !(pop && mq.size() == 1);
`endif
    if (st && coal) begin
      for (int j = 0; j < sz; j++) mq[mq.size()-1].bytes[8*(off+j) +: 8] = d[8*j +: 8];
      mq[mq.size()-1].be = mq[mq.size()-1].be | be;
    end
    if (st && !coal && mq.size() < N) begin
      ent_t e;
      e.lane = lane; e.be = be; e.bytes = '0;
      for (int j = 0; j < sz; j++) e.bytes[8*(off+j) +: 8] = d[8*j +: 8];
      if (pop) void'(mq.pop_front());
      mq.push_back(e);
    end else if (pop) void'(mq.pop_front());
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 32'h0, 32'h0, 2'd0, rdy);
  endtask

  // Scoreboard monitor: consumes one expectation per cycle it finds queued.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("hit", 32'(hit), 32'(r.hit));
        chk("miss", 32'(miss), 32'(r.miss));
        chk("trouble", 32'(trouble), 32'(r.tr));
        if (r.ld) chk("load_data", dout, r.data);
        chk("empty", 32'(empty), 32'(r.empty));
        chk("full", 32'(full), 32'(r.full));
        chk("drain_valid", 32'(dvld), 32'(r.dvld));
        if (r.dvld && drdy) begin
          chk("drain_addr", daddr, r.daddr);
          chk("drain_data", ddata, r.ddata);
          chk("drain_be", 32'(dbe), 32'(r.dbe));
        end
      end
    end
  end

  task automatic do_reset(input logic [31:0] probe);
    @(posedge clk); #1;
    rsn = 1'b0; req_store = 0; req_load = 1; addr = probe; dtype = 2'd2; drdy = 0;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_drain_valid", 32'(dvld), 32'd0);
    chk("rst_miss", 32'(miss), 32'd1);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_drain_addr", daddr, 32'd0);
    mq.delete();
    @(posedge clk); #1;
    rsn = 1'b1; req_load = 0;
  endtask

  initial begin
    do_reset(32'h0);
    // Fill, overflow, ordered drain
    for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 2'd2, 0);
    for (int i = 0; i < 6; i++) idle(1);
    // Forwarding, miss on neighbouring word
    step(1, 0, 32'h200, 32'hAABB_CCDD, 2'd2, 0);
    step(0, 1, 32'h202, 32'h0, 2'd0, 0);
    step(0, 1, 32'h204, 32'h0, 2'd1, 0);
    step(0, 1, 32'h203, 32'h0, 2'd1, 0);
    for (int i = 0; i < 2; i++) idle(1);
    // Partial overlap then drain
    step(1, 0, 32'h300, 32'h0000_0011, 2'd0, 0);
    step(0, 1, 32'h300, 32'h0, 2'd2, 0);
    step(0, 1, 32'h300, 32'h0, 2'd0, 0);
    idle(1);
    step(0, 1, 32'h300, 32'h0, 2'd2, 0);
    // Youngest wins, same-cycle store is invisible to the load
    step(1, 0, 32'h400, 32'h1, 2'd2, 0);
    step(1, 1, 32'h400, 32'h2, 2'd2, 0);
    step(0, 1, 32'h400, 32'h0, 2'd2, 0);
    step(1, 0, 32'h401, 32'h77, 2'd0, 0);
    step(0, 1, 32'h400, 32'h0, 2'd2, 0);
    for (int i = 0; i < 4; i++) idle(1);
    // Wrap with steady push+pop, then push+pop while full
    step(1, 0, 32'h600, 32'h10, 2'd2, 0);
    step(1, 0, 32'h604, 32'h11, 2'd2, 0);
    for (int i = 0; i < 3*N; i++) step(1, 0, 32'h608 + 32'(4*i), 32'h20 + 32'(i), 2'd2, 1);
    step(1, 0, 32'h700, 32'h30, 2'd2, 0);
    step(1, 0, 32'h704, 32'h31, 2'd2, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h708 + 32'(4*i), 32'h40 + 32'(i), 2'd2, 1);
    for (int i = 0; i < 6; i++) idle(1);
    // Random traffic in a small window to provoke overlaps
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0), 32'h500 + 32'($urandom_range(0, 11)),
           $urandom, 2'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0));
    // Reset mid-traffic with data buffered at the probed address
    step(1, 0, 32'h800, 32'h5, 2'd2, 0);
    step(1, 0, 32'h804, 32'h6, 2'd2, 0);
    @(negedge clk);
    do_reset(32'h800);
    step(0, 1, 32'h800, 32'h0, 2'd2, 0);
    for (int i = 0; i < 2; i++) idle(1);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
